// File: rtl/seg_msg_display.sv
// seg_msg_display: latches event messages, shows them on a multiplexed
// N-digit 7-segment display (scrolling when too long) and drives a buzzer.
module seg_msg_display #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int SCROLL_DIV       = 25000000,
  parameter int BEEP_DIV         = 12500,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buzz,
  input  logic                  err,
  input  logic                  on,
  input  logic                  off,
  input  logic                  open,
  output logic                  buzzer,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit,
  output logic [2:0]            msg_id,
  output logic                  scrolling
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int SCR_W  = $clog2(SCROLL_DIV);
  localparam int BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  localparam logic [REF_W-1:0]  REF_MAX  = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCR_W-1:0]  SCR_MAX  = SCR_W'(SCROLL_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(BEEP_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]        ND       = 4'(NUM_DIGITS);

  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                            : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_LEFT =
    {1'b1, {(NUM_DIGITS-1){1'b0}}};

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_BUZZ = 3'd1;
  localparam logic [2:0] M_ERR  = 3'd2;
  localparam logic [2:0] M_ON   = 3'd3;
  localparam logic [2:0] M_OFF  = 3'd4;
  localparam logic [2:0] M_OPEN = 3'd5;

  // Active-high glyphs, bit0 = a .. bit6 = g
  localparam logic [6:0] G_LB = 7'h7C;
  localparam logic [6:0] G_U  = 7'h3E;
  localparam logic [6:0] G_Z  = 7'h5B;
  localparam logic [6:0] G_E  = 7'h79;
  localparam logic [6:0] G_R  = 7'h50;
  localparam logic [6:0] G_O  = 7'h3F;
  localparam logic [6:0] G_N  = 7'h54;
  localparam logic [6:0] G_F  = 7'h71;
  localparam logic [6:0] G_P  = 7'h73;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STATIC,
    S_SCROLL
  } state_t;

  function automatic logic [2:0] msg_len(input logic [2:0] id);
    logic [2:0] l;
    case (id)
      M_BUZZ:  l = 3'd4;
      M_ERR:   l = 3'd3;
      M_ON:    l = 3'd2;
      M_OFF:   l = 3'd3;
      M_OPEN:  l = 3'd4;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  function automatic logic [6:0] glyph(
    input logic [2:0] id,
    input logic [2:0] pos
  );
    logic [6:0] g;
    g = 7'h00;
    case (id)
      M_BUZZ:
        case (pos)
          3'd0:       g = G_LB;
          3'd1:       g = G_U;
          3'd2, 3'd3: g = G_Z;
          default:    g = 7'h00;
        endcase
      M_ERR:
        case (pos)
          3'd0:       g = G_E;
          3'd1, 3'd2: g = G_R;
          default:    g = 7'h00;
        endcase
      M_ON:
        case (pos)
          3'd0:    g = G_O;
          3'd1:    g = G_N;
          default: g = 7'h00;
        endcase
      M_OFF:
        case (pos)
          3'd0:       g = G_O;
          3'd1, 3'd2: g = G_F;
          default:    g = 7'h00;
        endcase
      M_OPEN:
        case (pos)
          3'd0:    g = G_O;
          3'd1:    g = G_P;
          3'd2:    g = G_E;
          3'd3:    g = G_N;
          default: g = 7'h00;
        endcase
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Request bits: 0 buzz, 1 err, 2 on, 3 off, 4 open
  logic [4:0] w_req;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_sync3;
  logic [4:0] w_rise;
  logic       w_accept;
  logic [2:0] w_new_id;
  logic [2:0] w_new_len;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_msg;
  logic [2:0] w_msg_next;
  logic [2:0] w_len;
  logic [3:0] w_len_p1;

  logic [SCR_W-1:0]  r_scr_cnt;
  logic              w_scr_tick;
  logic [2:0]        r_ofs;
  logic [2:0]        r_phase;
  logic [2:0]        w_phase_next;

  logic [BEEP_W-1:0] r_beep_cnt;
  logic              w_beep_tick;
  logic              r_tone;
  logic              w_tone_next;
  logic              w_gate;
  logic              r_buzzer;

  logic [REF_W-1:0]  r_ref_cnt;
  logic              w_ref_tick;
  logic [IDX_W-1:0]  r_idx;

  logic [3:0]        w_idx4;
  logic [3:0]        w_sum;
  logic [3:0]        w_wrap;
  logic [2:0]        w_pos;
  logic              w_vis;
  logic [6:0]        w_glyph;
  logic [7:0]        w_seg_on;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [7:0]        r_seg;
  logic [NUM_DIGITS-1:0] r_digit;

  assign w_req = {open, off, on, err, buzz};

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= w_req;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise   = r_sync2 & ~r_sync3;
  assign w_accept = |w_rise;

  // Resolve simultaneous edges: err > buzz > open > off > on
  always_comb begin
    w_new_id = M_NONE;
    if (w_rise[1])      w_new_id = M_ERR;
    else if (w_rise[0]) w_new_id = M_BUZZ;
    else if (w_rise[4]) w_new_id = M_OPEN;
    else if (w_rise[3]) w_new_id = M_OFF;
    else if (w_rise[2]) w_new_id = M_ON;
  end

  assign w_new_len = msg_len(w_new_id);
  assign w_len     = msg_len(r_msg);
  assign w_len_p1  = {1'b0, w_len} + 4'd1;

  // Message/state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_msg   <= M_NONE;
    end else begin
      r_state <= w_state_next;
      r_msg   <= w_msg_next;
    end
  end

  // Any accepted edge picks static or scrolling display by length
  always_comb begin
    w_state_next = r_state;
    w_msg_next   = r_msg;
    if (w_accept) begin
      w_msg_next = w_new_id;
      if ({1'b0, w_new_len} > ND) w_state_next = S_SCROLL;
      else                        w_state_next = S_STATIC;
    end
  end

  assign w_scr_tick   = (r_scr_cnt == SCR_MAX);
  assign w_phase_next = (w_scr_tick && r_phase != 3'd5)
                      ? r_phase + 3'd1 : r_phase;

  // Slow timebase: scroll offset and err beep phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scr_cnt <= '0;
      r_ofs     <= '0;
      r_phase   <= '0;
    end else if (w_accept) begin
      r_scr_cnt <= '0;
      r_ofs     <= '0;
      r_phase   <= '0;
    end else begin
      r_scr_cnt <= w_scr_tick ? '0 : r_scr_cnt + SCR_W'(1);
      r_phase   <= w_phase_next;
      if (w_scr_tick && r_state == S_SCROLL)
        r_ofs <= (r_ofs == w_len) ? 3'd0 : r_ofs + 3'd1;
    end
  end

  assign w_beep_tick = (r_beep_cnt == BEEP_MAX);
  assign w_tone_next = r_tone ^ w_beep_tick;

  // err sounds on even phases only; phase 5 is the silent end state
  always_comb begin
    w_gate = 1'b0;
    if (r_msg == M_BUZZ)     w_gate = 1'b1;
    else if (r_msg == M_ERR) w_gate = ~w_phase_next[0];
  end

  // Tone generator and gated buzzer output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beep_cnt <= '0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else if (w_accept) begin
      r_beep_cnt <= '0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_beep_cnt <= w_beep_tick ? '0 : r_beep_cnt + BEEP_W'(1);
      r_tone     <= w_tone_next;
      r_buzzer   <= w_tone_next & w_gate;
    end
  end

  assign w_ref_tick = (r_ref_cnt == REF_MAX);

  // Digit scan timebase, index 0 is the leftmost digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
    end else begin
      r_ref_cnt <= w_ref_tick ? '0 : r_ref_cnt + REF_W'(1);
      if (w_ref_tick)
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign w_idx4 = 4'(r_idx);
  assign w_sum  = {1'b0, r_ofs} + w_idx4;

  // Character position for the digit being scanned
  always_comb begin
    w_pos  = 3'd0;
    w_vis  = 1'b0;
    w_wrap = w_sum;
    unique case (r_state)
      S_STATIC: begin
        w_pos = w_idx4[2:0];
        w_vis = (w_idx4 < {1'b0, w_len});
      end
      S_SCROLL: begin
        if (w_sum >= w_len_p1) w_wrap = w_sum - w_len_p1;
        w_pos = w_wrap[2:0];
        w_vis = (w_wrap < {1'b0, w_len});
      end
      default: begin
        w_pos = 3'd0;
        w_vis = 1'b0;
      end
    endcase
  end

  assign w_glyph  = w_vis ? glyph(r_msg, w_pos) : 7'h00;
  assign w_seg_on = {1'b0, w_glyph};
  assign w_onehot = DIG_LEFT >> r_idx;

  // Segments and enables registered together to avoid ghosting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg   <= SEG_OFF;
      r_digit <= DIG_OFF;
    end else begin
      r_seg   <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
      r_digit <= (DIGIT_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    end
  end

  assign seg       = r_seg;
  assign digit     = r_digit;
  assign buzzer    = r_buzzer;
  assign msg_id    = r_msg;
  assign scrolling = (r_state == S_SCROLL);

endmodule

// File: tb/tb_seg_msg_display.sv
// tb_seg_msg_display: scoreboard bench for seg_msg_display,
// a 4-digit instance plus a 2-digit instance for scrolling.
module tb_seg_msg_display;
  localparam int RD = 4;
  localparam int SD = 16;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic buzz = 0, err = 0, on = 0, off = 0, open = 0;
  logic buzzer1, scr1;
  logic [7:0] seg1;
  logic [3:0] dig1;
  logic [2:0] msg1;

  logic buzz2 = 0, err2 = 0, on2 = 0, off2 = 0, open2 = 0;
  logic buzzer2, scr2;
  logic [7:0] seg2;
  logic [1:0] dig2;
  logic [2:0] msg2;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [7:0] q_seg[$];
  logic [3:0] q_dig[$];
  logic [1:0] q_dig2[$];
  logic       q_buz[$];

  seg_msg_display #(
    .NUM_DIGITS(4), .REFRESH_DIV(RD), .SCROLL_DIV(SD),
    .BEEP_DIV(BD), .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst(rst), .buzz(buzz), .err(err), .on(on),
    .off(off), .open(open), .buzzer(buzzer1), .seg(seg1),
    .digit(dig1), .msg_id(msg1), .scrolling(scr1)
  );

  seg_msg_display #(
    .NUM_DIGITS(2), .REFRESH_DIV(RD), .SCROLL_DIV(SD),
    .BEEP_DIV(BD), .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut2 (
    .clk(clk), .rst(rst), .buzz(buzz2), .err(err2), .on(on2),
    .off(off2), .open(open2), .buzzer(buzzer2), .seg(seg2),
    .digit(dig2), .msg_id(msg2), .scrolling(scr2)
  );

  always #5 clk = ~clk;

  // Edges since reset release
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] glyph(int msg, int i);
    logic [7:0] t [0:3];
    case (msg)
      1: t = '{8'h83, 8'hC1, 8'hA4, 8'hA4};
      2: t = '{8'h86, 8'hAF, 8'hAF, 8'hFF};
      3: t = '{8'hC0, 8'hAB, 8'hFF, 8'hFF};
      4: t = '{8'hC0, 8'h8E, 8'h8E, 8'hFF};
      5: t = '{8'hC0, 8'h8C, 8'h86, 8'hAB};
      default: t = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    endcase
    if (i < 0 || i > 3) return 8'hFF;
    return t[i];
  endfunction

  function automatic int mlen(int msg);
    case (msg)
      1: return 4;
      2: return 3;
      3: return 2;
      4: return 3;
      5: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(int msg, int nd, int k, int idx);
    int l, p;
    l = mlen(msg);
    if (l == 0) return 8'hFF;
    if (l <= nd) return (idx < l) ? glyph(msg, idx) : 8'hFF;
    p = (k + idx) % (l + 1);
    return (p < l) ? glyph(msg, p) : 8'hFF;
  endfunction

  function automatic logic [3:0] exp_dig4(int n);
    logic [3:0] t;
    t = 4'b1000 >> (((n - 1) / RD) % 4);
    return ~t;
  endfunction

  function automatic logic [1:0] exp_dig2(int n);
    logic [1:0] t;
    t = 2'b10 >> (((n - 1) / RD) % 2);
    return ~t;
  endfunction

  task automatic test_reset;
    logic [7:0] es;
    logic [3:0] ed;
    es = 8'hFF;
    ed = 4'hF;
    repeat (3) tick;
    checks++;
    if (dig1 !== ed) begin
      errors++; $display("FAIL rst_digit: got %h want %h", dig1, ed);
    end
    checks++;
    if (seg1 !== es) begin
      errors++; $display("FAIL rst_seg: got %h want %h", seg1, es);
    end
    checks++;
    if (buzzer1 !== 1'b0 || msg1 !== 3'd0 || scr1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_misc: got buz=%b id=%0d scr=%b want 0 0 0",
               buzzer1, msg1, scr1);
    end
    checks++;
    if (dig2 !== 2'b11) begin
      errors++; $display("FAIL rst_digit2: got %h want 3", dig2);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_scan;
    for (int n = cyc + 1; n <= cyc + 24; n++) q_dig.push_back(exp_dig4(n));
    for (int i = 0; i < 24; i++) begin
      logic [3:0] e;
      tick;
      e = q_dig.pop_front();
      checks++;
      if (dig1 !== e) begin
        errors++; $display("FAIL scan_digit n=%0d: got %h want %h", cyc, dig1, e);
      end
      checks++;
      if (seg1 !== 8'hFF) begin
        errors++; $display("FAIL idle_seg n=%0d: got %h want ff", cyc, seg1);
      end
    end
  endtask

  task automatic test_on;
    int e0;
    on = 1'b1;
    tick;
    tick;
    checks++;
    if (msg1 !== 3'd0) begin
      errors++; $display("FAIL on_early: got %0d want 0", msg1);
    end
    tick;
    on = 1'b0;
    checks++;
    if (msg1 !== 3'd3 || scr1 !== 1'b0) begin
      errors++;
      $display("FAIL on_latch: got id=%0d scr=%b want 3 0", msg1, scr1);
    end
    e0 = cyc;
    for (int n = e0 + 1; n <= e0 + 24; n++) begin
      q_seg.push_back(exp_seg(3, 4, 0, ((n - 1) / RD) % 4));
      q_dig.push_back(exp_dig4(n));
      q_buz.push_back(1'b0);
    end
    for (int i = 0; i < 24; i++) begin
      logic [7:0] es;
      logic [3:0] ed;
      logic eb;
      tick;
      es = q_seg.pop_front();
      ed = q_dig.pop_front();
      eb = q_buz.pop_front();
      checks++;
      if (seg1 !== es || dig1 !== ed || buzzer1 !== eb) begin
        errors++;
        $display("FAIL on_disp n=%0d: got seg=%h dig=%h buz=%b want %h %h %b",
                 cyc, seg1, dig1, buzzer1, es, ed, eb);
      end
    end
  endtask

  task automatic test_err_beep;
    int e0;
    err = 1'b1;
    buzz = 1'b1;
    repeat (3) tick;
    err = 1'b0;
    buzz = 1'b0;
    checks++;
    if (msg1 !== 3'd2) begin
      errors++; $display("FAIL err_prio: got %0d want 2", msg1);
    end
    e0 = cyc;
    for (int j = 0; j < 100; j++) begin
      int ph;
      ph = (j / SD > 5) ? 5 : j / SD;
      q_buz.push_back(((j / BD) % 2 == 1) && (ph % 2 == 0) && ph < 5);
      if (j > 0) q_seg.push_back(exp_seg(2, 4, 0, ((e0 + j - 1) / RD) % 4));
    end
    for (int j = 0; j < 100; j++) begin
      logic eb;
      logic [7:0] es;
      eb = q_buz.pop_front();
      checks++;
      if (buzzer1 !== eb) begin
        errors++; $display("FAIL err_beep j=%0d: got %b want %b", j, buzzer1, eb);
      end
      if (j > 0) begin
        es = q_seg.pop_front();
        checks++;
        if (seg1 !== es) begin
          errors++; $display("FAIL err_seg j=%0d: got %h want %h", j, seg1, es);
        end
      end
      if (j < 99) tick;
    end
  endtask

  task automatic test_buzz_hold;
    buzz = 1'b1;
    repeat (3) tick;
    for (int j = 0; j < 200; j++) q_buz.push_back((j / BD) % 2 == 1);
    for (int j = 0; j < 200; j++) begin
      logic eb;
      eb = q_buz.pop_front();
      checks++;
      if (buzzer1 !== eb || msg1 !== 3'd1) begin
        errors++;
        $display("FAIL buzz_hold j=%0d: got buz=%b id=%0d want %b 1",
                 j, buzzer1, msg1, eb);
      end
      if (j < 199) tick;
    end
    off = 1'b1;
    buzz = 1'b0;
    repeat (3) tick;
    off = 1'b0;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (msg1 !== 3'd4 || buzzer1 !== 1'b0) begin
        errors++;
        $display("FAIL off_switch j=%0d: got id=%0d buz=%b want 4 0",
                 j, msg1, buzzer1);
      end
      tick;
    end
  endtask

  task automatic scroll_window(int e0, int cnt, string tag);
    for (int n = e0 + 1; n <= e0 + cnt; n++) begin
      q_seg.push_back(exp_seg(5, 2, ((n - 1 - e0) / SD) % 5, ((n - 1) / RD) % 2));
      q_dig2.push_back(exp_dig2(n));
    end
    for (int i = 0; i < cnt; i++) begin
      logic [7:0] es;
      logic [1:0] ed;
      tick;
      es = q_seg.pop_front();
      ed = q_dig2.pop_front();
      checks++;
      if (seg2 !== es || dig2 !== ed || scr2 !== 1'b1) begin
        errors++;
        $display("FAIL %s n=%0d: got seg=%h dig=%h scr=%b want %h %h 1",
                 tag, cyc, seg2, dig2, scr2, es, ed);
      end
    end
  endtask

  task automatic test_scroll;
    int e0;
    open2 = 1'b1;
    repeat (3) tick;
    open2 = 1'b0;
    checks++;
    if (msg2 !== 3'd5 || scr2 !== 1'b1) begin
      errors++;
      $display("FAIL scroll_latch: got id=%0d scr=%b want 5 1", msg2, scr2);
    end
    e0 = cyc;
    scroll_window(e0, 100, "scroll_win");
    open2 = 1'b1;
    repeat (3) tick;
    open2 = 1'b0;
    e0 = cyc;
    scroll_window(e0, 40, "scroll_restart");
  endtask

  task automatic test_async_reset;
    err = 1'b1;
    repeat (3) tick;
    err = 1'b0;
    repeat (6) tick;
    checks++;
    if (buzzer1 !== 1'b1) begin
      errors++; $display("FAIL pre_rst_beep: got %b want 1", buzzer1);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dig1 !== 4'hF || seg1 !== 8'hFF) begin
      errors++;
      $display("FAIL arst_disp: got dig=%h seg=%h want f ff", dig1, seg1);
    end
    checks++;
    if (buzzer1 !== 1'b0 || msg1 !== 3'd0 || scr1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_misc: got buz=%b id=%0d scr=%b want 0 0 0",
               buzzer1, msg1, scr1);
    end
    checks++;
    if (dig2 !== 2'b11 || msg2 !== 3'd0 || scr2 !== 1'b0) begin
      errors++;
      $display("FAIL arst_dut2: got dig=%h id=%0d scr=%b want 3 0 0",
               dig2, msg2, scr2);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) tick;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_on;
    test_err_beep;
    test_buzz_hold;
    test_scroll;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
